// File: rtl/mem_stage_if.sv
// Data-memory handshake bus between the memory stage (master) and data memory (slave).
interface mem_stage_if;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;

  modport master (output dm_req, dm_we, dm_addr, dm_be, dm_wdata,
                  input  dm_rdata, dm_ack);
  modport slave  (input  dm_req, dm_we, dm_addr, dm_be, dm_wdata,
                  output dm_rdata, dm_ack);
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: sized loads/stores over a handshaked port,
// redirect resolution, memory stall with timeout abort, and the MEM/WB register.
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  EX_MEM_LS_bit,
  input  logic [1:0]  EX_MEM_Branch,
  input  logic        EX_MEM_MemtoReg,
  input  logic        EX_MEM_MemWrite,
  input  logic        EX_MEM_RegWrite,
  input  logic        EX_MEM_Jump,
  input  logic        EX_MEM_Ext_op,
  input  logic        EX_MEM_PctoReg,
  input  logic        EX_MEM_JR,
  input  logic [31:0] EX_MEM_branch_add_out,
  input  logic        EX_MEM_zero,
  input  logic [31:0] EX_MEM_pc_add_out,
  input  logic [25:0] EX_MEM_instr26,
  input  logic [31:0] EX_MEM_alu_out,
  input  logic [31:0] EX_MEM_regfile_out1,
  input  logic [31:0] EX_MEM_regfile_out2,
  input  logic [4:0]  EX_MEM_mux1_out,
  mem_stage_if.master bus,
  output logic        mem_stall,
  output logic        pc_redirect,
  output logic [31:0] pc_target,
  output logic        MEM_WB_RegWrite,
  output logic [31:0] MEM_WB_wb_data,
  output logic [4:0]  MEM_WB_mux1_out,
  output logic        misalign_err,
  output logic        bus_err
);
  // wait_cnt only needs to reach TIMEOUT_CYCLES-1
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic {IDLE, WAIT} state_t;
  state_t        state;
  logic [CW-1:0] wait_cnt;

  logic        access, is_byte, is_half, is_word, misaligned, abort, br_taken;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_val, wb_next;

  assign access     = EX_MEM_MemtoReg | EX_MEM_MemWrite;
  assign is_byte    = (EX_MEM_LS_bit == 2'b10);
  assign is_half    = (EX_MEM_LS_bit == 2'b01);
  assign is_word    = !is_byte && !is_half;  // 11 behaves as word
  // Only real memory accesses can be misaligned; ALU results are unconstrained.
  assign misaligned = access & ((is_half & EX_MEM_alu_out[0]) | (is_word & |EX_MEM_alu_out[1:0]));
  // Abort fires in the last WAIT cycle unless the ack arrives in that same cycle.
  assign abort      = (state == WAIT) && !bus.dm_ack && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

  assign bus.dm_req  = access & ~misaligned & ~abort;
  assign bus.dm_we   = EX_MEM_MemWrite;
  assign bus.dm_addr = {EX_MEM_alu_out[31:2], 2'b00};
  assign mem_stall   = bus.dm_req & ~bus.dm_ack;

  // Byte enables and lane-replicated store data by access size.
  always_comb begin
    bus.dm_be    = 4'hF;
    bus.dm_wdata = EX_MEM_regfile_out2;
    if (is_byte) begin
      bus.dm_be    = 4'b0001 << EX_MEM_alu_out[1:0];
      bus.dm_wdata = {4{EX_MEM_regfile_out2[7:0]}};
    end else if (is_half) begin
      bus.dm_be    = 4'b0011 << {EX_MEM_alu_out[1], 1'b0};
      bus.dm_wdata = {2{EX_MEM_regfile_out2[15:0]}};
    end
  end

  // Select the addressed lane from read data and extend it.
  always_comb begin
    ld_byte  = bus.dm_rdata[{EX_MEM_alu_out[1:0], 3'b000} +: 8];
    ld_half  = EX_MEM_alu_out[1] ? bus.dm_rdata[31:16] : bus.dm_rdata[15:0];
    load_val = bus.dm_rdata;
    if (is_byte)
      load_val = {{24{EX_MEM_Ext_op & ld_byte[7]}}, ld_byte};
    else if (is_half)
      load_val = {{16{EX_MEM_Ext_op & ld_half[15]}}, ld_half};
    wb_next = EX_MEM_PctoReg ? EX_MEM_pc_add_out : (EX_MEM_MemtoReg ? load_val : EX_MEM_alu_out);
  end

  // Redirect resolution; a stalled access holds off any redirect until it completes.
  always_comb begin
    br_taken    = ((EX_MEM_Branch == 2'b01) && EX_MEM_zero) ||
                  ((EX_MEM_Branch == 2'b10) && !EX_MEM_zero);
    pc_redirect = 1'b0;
    pc_target   = '0;
    if (!mem_stall) begin
      if (EX_MEM_JR) begin
        pc_redirect = 1'b1;
        pc_target   = EX_MEM_regfile_out1;
      end else if (EX_MEM_Jump) begin
        pc_redirect = 1'b1;
        pc_target   = {EX_MEM_pc_add_out[31:28], EX_MEM_instr26, 2'b00};
      end else if (br_taken) begin
        pc_redirect = 1'b1;
        pc_target   = EX_MEM_branch_add_out;
      end
    end
  end

  // Outstanding-request tracker: counts un-acked cycles toward the timeout.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (bus.dm_req && !bus.dm_ack) begin
          state    <= WAIT;
          wait_cnt <= CW'(1);
        end
        WAIT: if (bus.dm_ack || abort) begin
          state    <= IDLE;
          wait_cnt <= '0;
        end else begin
          wait_cnt <= wait_cnt + 1'b1;
        end
        default: begin
          state    <= IDLE;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  // MEM/WB register with bubble insertion on stall, plus sticky error flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      MEM_WB_RegWrite <= 1'b0;
      MEM_WB_wb_data  <= '0;
      MEM_WB_mux1_out <= '0;
      misalign_err    <= 1'b0;
      bus_err         <= 1'b0;
    end else begin
      if (misaligned) misalign_err <= 1'b1;
      if (abort)      bus_err      <= 1'b1;
      if (mem_stall) begin
        MEM_WB_RegWrite <= 1'b0;
        MEM_WB_wb_data  <= '0;
        MEM_WB_mux1_out <= '0;
      end else begin
        MEM_WB_RegWrite <= EX_MEM_RegWrite & ~misaligned & ~abort;
        MEM_WB_wb_data  <= wb_next;
        MEM_WB_mux1_out <= EX_MEM_mux1_out;
      end
    end
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the multistage pipeline, directly downstream of the EX/MEM register.
- Performs loads and stores through a handshaked data-memory port, covering word, halfword and byte accesses with byte lanes and sign or zero extension.
- Resolves branch, jump and JR redirects and produces the pipeline flush.
- Stalls the pipeline while memory is outstanding and registers the write-back bundle (the MEM/WB register).

Parameters:
TIMEOUT_CYCLES, 16, number of un-acked request cycles after which the access is aborted (minimum 2).

Ports:
clock  in  1  pipeline clock, rising edge.
reset  in  1  asynchronous, active-high.
EX_MEM_LS_bit  in  2  access size: 00 word, 01 half, 10 byte, 11 treated as word.
EX_MEM_Branch  in  2  00 none, 01 beq, 10 bne, 11 none.
EX_MEM_MemtoReg  in  1  load.
EX_MEM_MemWrite  in  1  store.
EX_MEM_RegWrite  in  1  register write enable.
EX_MEM_Jump  in  1  j/jal.
EX_MEM_Ext_op  in  1  1 sign-extend load, 0 zero-extend.
EX_MEM_PctoReg  in  1  write back pc_add_out (link).
EX_MEM_JR  in  1  jump register.
EX_MEM_branch_add_out  in  32  branch target.
EX_MEM_zero  in  1  ALU zero flag.
EX_MEM_pc_add_out  in  32  PC+4.
EX_MEM_instr26  in  26  jump index.
EX_MEM_alu_out  in  32  address / ALU result.
EX_MEM_regfile_out1  in  32  rs value (JR target).
EX_MEM_regfile_out2  in  32  rt value (store data).
EX_MEM_mux1_out  in  5  destination register.
dm_req  out  1  memory request.
dm_we  out  1  write strobe.
dm_addr  out  32  {alu_out[31:2],2'b00}.
dm_be  out  4  byte enables.
dm_wdata  out  32  lane-replicated store data.
dm_rdata  in  32  read data, valid with dm_ack.
dm_ack  in  1  completes the current request.
mem_stall  out  1  hold PC, IF/ID, ID/EX and EX/MEM.
pc_redirect  out  1  take pc_target, flush younger stages.
pc_target  out  32  redirect address.
MEM_WB_RegWrite  out  1  registered.
MEM_WB_wb_data  out  32  registered write-back value.
MEM_WB_mux1_out  out  5  registered.
misalign_err  out  1  sticky.
bus_err  out  1  sticky.

Behaviour:
- Access definition: `access = MemtoReg|MemWrite`.
  - Misaligned when half with `alu_out[0]=1`, or word with `alu_out[1:0]≠0`.
  - A misaligned access issues no request and sets `misalign_err`.
- `dm_req = access & ~misaligned & ~abort`; `dm_we = MemWrite`.
- Byte enables and store data:
  - Byte: `dm_be = 4'b0001<<alu_out[1:0]`, `dm_wdata = {4{rt[7:0]}}`.
  - Half: `dm_be = 4'b0011<<(2*alu_out[1])`, `dm_wdata = {2{rt[15:0]}}`.
  - Word: `dm_be = 4'hF`, `dm_wdata = rt`.
  - Loads drive the same byte enables.
- Load extraction: select the byte or half lane by `alu_out[1:0]`, then extend per `Ext_op`.
- Stall: `mem_stall = dm_req & ~dm_ack` (combinational). A zero-wait ack completes the access in its first cycle.
- FSM:
  - IDLE: `dm_req & ~dm_ack` → WAIT, with `wait_cnt=1`.
  - WAIT: `dm_ack` → IDLE. Otherwise, if `wait_cnt=TIMEOUT_CYCLES-1`, set `abort` for that cycle, set `bus_err`, go to IDLE. Otherwise increment `wait_cnt`.
  - During the abort cycle, `dm_req=0` and `mem_stall=0`; the instruction retires with `RegWrite` suppressed.
- Redirect: evaluated only in cycles with `mem_stall=0`. Priority is JR > Jump > taken branch.
  - JR target = `regfile_out1`.
  - Jump target = `{pc_add_out[31:28], instr26, 2'b00}`.
  - beq is taken if `zero`; bne is taken if `~zero`.
  - `pc_redirect` is held 0 while stalled. `pc_target` = 0 when no redirect.
- MEM/WB register, updated on each rising clock:
  - Stalled cycle: insert a bubble (`RegWrite=0`, `wb_data=0`, `mux1_out=0`).
  - Otherwise:
    - `RegWrite = EX_MEM_RegWrite & ~misaligned & ~abort`.
    - `wb_data` = `PctoReg` ? `pc_add_out` : `MemtoReg` ? extended load : `alu_out`.
    - `mux1_out` passes through.
- Reset: all MEM/WB outputs are 0, FSM is IDLE, `wait_cnt`=0, both sticky error flags are 0.
  - Combinational outputs follow the inputs, with the FSM forced to IDLE.
  - Reset asserted mid-WAIT abandons the access immediately.
- Error flags: both are sticky until reset.
- Simultaneous events: an ack arriving on the timeout cycle wins (normal completion, no `bus_err`). A branch/jump never co-occurs with an access, but if it does, the redirect waits for the access to complete.

Test Plan:
- Word load, `alu_out=0x100`, ack after 3 cycles, `rdata=0xDEADBEEF` → `mem_stall` high for 3 cycles; next edge `MEM_WB_wb_data=0xDEADBEEF`, `RegWrite=1`; bubbles during the stall.
- Byte loads, `rdata=0x80FF7F01`, zero-wait ack, addr offsets 0..3, `Ext_op=1` → `wb_data` 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80; with `Ext_op=0`, offset 3 → 0x00000080.
- Half store, `rt=0x1234ABCD`, `alu_out=0x202` → `dm_addr=0x200`, `dm_be=4'b1100`, `dm_wdata=0xABCDABCD`, `dm_we=1`. Word store at 0x201 → no `dm_req`, `misalign_err=1`, `RegWrite` suppressed.
- `dm_ack` never arrives, `TIMEOUT_CYCLES=16` → `mem_stall` high 15 cycles, abort cycle: `dm_req=0`, `bus_err=1`, `MEM_WB_RegWrite=0`. Repeat with ack exactly on cycle 15 → no `bus_err`.
- Redirects:
  - beq, `zero=1`, `branch_add_out=0x3010` → `pc_redirect=1`, `pc_target=0x3010`.
  - bne, `zero=1` → `pc_redirect=0`.
  - Jump, `pc_add_out=0x30000004`, `instr26=0x0000C01` → target 0x30003004.
  - JR plus Jump together, `rs=0x4000` → target 0x4000.
  - jal with `PctoReg` → `wb_data=pc_add_out`.
- Reset asserted in WAIT cycle 2 (asynchronous, mid-cycle) → MEM/WB outputs clear immediately, FSM IDLE, error flags 0; after release a new load completes normally.
